// File: rtl/cnn_layer_accel_seq_pkg.sv
// Shared types and helpers for the CNN layer accelerator job sequencer.
package cnn_layer_accel_seq_pkg;

  localparam int CFG_SLOTS   = 4;
  localparam int CFG_WIDTH   = 128;
  localparam int PARAM_WIDTH = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_START,
    S_RUN,
    S_CACK,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [PARAM_WIDTH-1:0]                params;
    logic [CFG_SLOTS-1:0][CFG_WIDTH-1:0]   cfg;
    logic [CFG_SLOTS-1:0]                  mask;
  } job_desc_t;

  function automatic logic [CFG_SLOTS-1:0] lowest_onehot(input logic [CFG_SLOTS-1:0] m);
    return m & (-m);
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [CFG_SLOTS-1:0] m);
    lowest_idx = '0;
    for (int i = CFG_SLOTS - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/cnn_layer_accel_seq_watchdog.sv
// Loadable down-counter watchdog; expired is high once a loaded count has run down to zero.
module cnn_layer_accel_seq_watchdog #(
  parameter int C_TIMEOUT = 65535
) (
  input  logic clk_if,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(C_TIMEOUT + 1);

  logic [CW-1:0] count;
  logic          armed;

  // Loading C_TIMEOUT-1 makes expiry coincide with the C_TIMEOUT-th idle cycle.
  always_ff @(posedge clk_if) begin
    if (rst || clear) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= CW'(C_TIMEOUT - 1);
      armed <= 1'b1;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = armed && (count == '0);

endmodule

// File: rtl/cnn_layer_accel_job_sequencer.sv
// Sequences one quad job per host descriptor: config push, job start, fetch servicing, completion.
// Optional watchdog abort is compiled in with CNL_JOB_SEQ_TIMEOUT_EN.
module cnn_layer_accel_job_sequencer
  import cnn_layer_accel_seq_pkg::*;
#(
  parameter int C_CFG_WIDTH   = 128,
  parameter int C_PARAM_WIDTH = 128,
  parameter int C_CNT_WIDTH   = 16,
  parameter int C_TIMEOUT     = 65535
) (
  input  logic                           clk_if,
  input  logic                           rst,
  input  logic                           desc_valid,
  output logic                           desc_ready,
  input  logic [C_PARAM_WIDTH-1:0]       desc_params,
  input  logic [CFG_SLOTS*C_CFG_WIDTH-1:0] desc_cfg_data,
  input  logic [CFG_SLOTS-1:0]           desc_cfg_mask,
  output logic [CFG_SLOTS-1:0]           config_valid,
  input  logic [CFG_SLOTS-1:0]           config_accept,
  output logic [C_CFG_WIDTH-1:0]         config_data,
  output logic                           job_start,
  input  logic                           job_accept,
  output logic [C_PARAM_WIDTH-1:0]       job_parameters,
  input  logic                           job_fetch_request,
  output logic                           job_fetch_ack,
  input  logic                           job_fetch_complete,
  input  logic                           job_complete,
  output logic                           job_complete_ack,
  output logic                           done_valid,
  output logic                           done_status,
  output logic [C_CNT_WIDTH-1:0]         done_fetch_cnt,
  output logic                           busy
);

  seq_state_t                            state;
  logic [CFG_SLOTS-1:0][C_CFG_WIDTH-1:0] desc_words;
  logic [CFG_SLOTS-1:0][C_CFG_WIDTH-1:0] cfg_words;
  logic [CFG_SLOTS-1:0]                  pend_mask;
  logic [CFG_SLOTS-1:0]                  mask_rem;
  logic                                  fetch_pend;
  logic [C_CNT_WIDTH-1:0]                fetch_cnt;
  logic                                  timeout_hit;

  assign desc_words = desc_cfg_data;
  assign mask_rem   = pend_mask & ~config_valid;

`ifdef CNL_JOB_SEQ_TIMEOUT_EN
  logic active, progress, wd_expired;

  assign active   = (state == S_CFG) || (state == S_START) || (state == S_RUN);
  assign progress = (|config_accept) || job_accept || job_fetch_complete || job_complete;

  cnn_layer_accel_seq_watchdog #(.C_TIMEOUT(C_TIMEOUT)) u_watchdog (
    .clk_if  (clk_if),
    .rst     (rst),
    .clear   (state == S_DONE),
    .load    (((state == S_IDLE) && desc_valid) || (active && progress)),
    .en      (active),
    .expired (wd_expired)
  );

  assign timeout_hit = active && wd_expired && !progress;
`else
  // Watchdog compiled out: never fires.
  assign timeout_hit = (C_TIMEOUT < 0);
`endif

  always_ff @(posedge clk_if) begin
    if (rst) begin
      state            <= S_IDLE;
      desc_ready       <= 1'b1;
      busy             <= 1'b0;
      pend_mask        <= '0;
      config_valid     <= '0;
      config_data      <= '0;
      job_start        <= 1'b0;
      job_parameters   <= '0;
      job_fetch_ack    <= 1'b0;
      job_complete_ack <= 1'b0;
      done_valid       <= 1'b0;
      done_status      <= 1'b0;
      done_fetch_cnt   <= '0;
      fetch_pend       <= 1'b0;
      fetch_cnt        <= '0;
    end else begin
      job_fetch_ack    <= 1'b0;
      job_complete_ack <= 1'b0;
      done_valid       <= 1'b0;
      done_status      <= 1'b0;
      done_fetch_cnt   <= '0;
      if (timeout_hit) begin
        config_valid   <= '0;
        config_data    <= '0;
        job_start      <= 1'b0;
        fetch_pend     <= 1'b0;
        done_valid     <= 1'b1;
        done_status    <= 1'b1;
        done_fetch_cnt <= fetch_cnt;
        state          <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (desc_valid && desc_ready) begin
              job_parameters <= desc_params;
              cfg_words      <= desc_words;
              pend_mask      <= desc_cfg_mask;
              desc_ready     <= 1'b0;
              busy           <= 1'b1;
              fetch_pend     <= 1'b0;
              fetch_cnt      <= '0;
              if (desc_cfg_mask != '0) begin
                config_valid <= lowest_onehot(desc_cfg_mask);
                config_data  <= desc_words[lowest_idx(desc_cfg_mask)];
                state        <= S_CFG;
              end else begin
                job_start    <= 1'b1;
                state        <= S_START;
              end
            end
          end
          S_CFG: begin
            if ((config_accept & config_valid) != '0) begin
              pend_mask <= mask_rem;
              if (mask_rem != '0) begin
                config_valid <= lowest_onehot(mask_rem);
                config_data  <= cfg_words[lowest_idx(mask_rem)];
              end else begin
                config_valid <= '0;
                config_data  <= '0;
                job_start    <= 1'b1;
                state        <= S_START;
              end
            end
          end
          S_START: begin
            if (job_accept) begin
              job_start <= 1'b0;
              state     <= S_RUN;
            end
          end
          S_RUN: begin
            if (job_fetch_complete) begin
              fetch_pend <= 1'b0;
              if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 1'b1;
            end
            // A completing fetch frees job_complete in the same cycle.
            if (job_complete && (!fetch_pend || job_fetch_complete)) begin
              job_complete_ack <= 1'b1;
              state            <= S_CACK;
            end else if (job_fetch_request && !fetch_pend) begin
              job_fetch_ack <= 1'b1;
              fetch_pend    <= 1'b1;
            end
          end
          S_CACK: begin
            done_valid     <= 1'b1;
            done_fetch_cnt <= fetch_cnt;
            state          <= S_DONE;
          end
          S_DONE: begin
            fetch_cnt  <= '0;
            desc_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
